// File: rtl/scan_chain_ctrl_if.sv
// Sequencer-side pattern/result channel of the scan chain controller.
// Patterns flow in on pat_*, captured responses flow back on res_*.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 8
);
  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] pat_data;
  logic [CHAIN_LEN-1:0] exp_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [CHAIN_LEN-1:0] res_data;
  logic                 res_mismatch;

  modport master (
    output pat_valid, pat_data, exp_data, res_ready,
    input  pat_ready, res_valid, res_data, res_mismatch
  );

  modport slave (
    input  pat_valid, pat_data, exp_data, res_ready,
    output pat_ready, res_valid, res_data, res_mismatch
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain driver: load pattern MSB first, pulse capture, unload and compare.
// Latency 2*CHAIN_LEN+CAPTURE_CYCLES edges accept->res_valid; result held until res_ready.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1,
  parameter bit FILL_BIT       = 1'b0,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  scan_chain_ctrl_if.slave  bus,
  output logic              scan_en,
  output logic              scan_sd,
  input  logic              scan_so,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  localparam int MAX_NC = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CW     = $clog2(MAX_NC + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] LAST_CAP   = CW'(CAPTURE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_sh_q, pat_sh_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] res_q, res_d;
  logic                 mis_q, mis_d;
  logic                 vld_q, vld_d;
  logic                 se_q, se_d;
  logic                 sd_q, sd_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_sh_d = pat_sh_q;
    exp_d    = exp_q;
    res_d    = res_q;
    mis_d    = mis_q;
    vld_d    = vld_q;
    se_d     = se_q;
    sd_d     = sd_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.pat_valid) begin
          // MSB goes out now; the shifter is pre-advanced so its top bit is the next one
          pat_sh_d = bus.pat_data << 1;
          exp_d    = bus.exp_data;
          se_d     = 1'b1;
          sd_d     = bus.pat_data[CHAIN_LEN-1];
          cnt_d    = '0;
          state_d  = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        if (cnt_q == LAST_SHIFT) begin
          se_d    = 1'b0;
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          sd_d     = pat_sh_q[CHAIN_LEN-1];
          pat_sh_d = pat_sh_q << 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        if (cnt_q == LAST_CAP) begin
          se_d    = 1'b1;
          sd_d    = FILL_BIT;
          cnt_d   = '0;
          state_d = SHIFT_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT_OUT: begin
        // Tail stage arrives first and ends up in the top bit
        res_d = {res_q[CHAIN_LEN-2:0], scan_so};
        if (cnt_q == LAST_SHIFT) begin
          se_d    = 1'b0;
          vld_d   = 1'b1;
          mis_d   = |(res_d ^ exp_q);
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
          if (mis_q && (err_q != {CNT_W{1'b1}})) err_d = err_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pat_sh_q <= '0;
      exp_q    <= '0;
      res_q    <= '0;
      mis_q    <= 1'b0;
      vld_q    <= 1'b0;
      se_q     <= 1'b0;
      sd_q     <= 1'b0;
      err_q    <= '0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pat_sh_q <= pat_sh_d;
      exp_q    <= exp_d;
      res_q    <= res_d;
      mis_q    <= mis_d;
      vld_q    <= vld_d;
      se_q     <= se_d;
      sd_q     <= sd_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.pat_ready    = rdy_q;
  assign bus.res_valid    = vld_q;
  assign bus.res_data     = res_q;
  assign bus.res_mismatch = mis_q;
  assign scan_en          = se_q;
  assign scan_sd          = sd_q;
  assign err_count        = err_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench: two controllers (8-bit and 2-bit error counters) each driving an
// 8-stage scan chain whose functional input is the inverted stage output.
module tb_scan_chain_ctrl;
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       pat_valid1, pat_valid2, res_ready;
  logic [7:0] pat_data, exp_data;
  int         total = 0;
  int         bad   = 0;

  scan_chain_ctrl_if #(.CHAIN_LEN(8)) b1 ();
  scan_chain_ctrl_if #(.CHAIN_LEN(8)) b2 ();

  assign b1.pat_valid = pat_valid1;
  assign b1.pat_data  = pat_data;
  assign b1.exp_data  = exp_data;
  assign b1.res_ready = res_ready;
  assign b2.pat_valid = pat_valid2;
  assign b2.pat_data  = pat_data;
  assign b2.exp_data  = exp_data;
  assign b2.res_ready = res_ready;

  logic       se1, sd1, so1, busy1, se2, sd2, so2, busy2;
  logic [7:0] err1;
  logic [1:0] err2;
  logic [7:0] ch1, ch2;

  // FF_scan chains: SE=1 shifts from SD toward stage 7, SE=0 loads D = ~Q
  always @(posedge clk) ch1 <= se1 ? {ch1[6:0], sd1} : ~ch1;
  always @(posedge clk) ch2 <= se2 ? {ch2[6:0], sd2} : ~ch2;
  assign so1 = ch1[7];
  assign so2 = ch2[7];

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1), .FILL_BIT(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave), .scan_en(se1), .scan_sd(sd1),
    .scan_so(so1), .err_count(err1), .busy(busy1)
  );

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1), .FILL_BIT(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave), .scan_en(se2), .scan_sd(sd2),
    .scan_so(so2), .err_count(err2), .busy(busy2)
  );

  task automatic run(input bit sel, input logic [7:0] pat, input logic [7:0] exp,
                     output int edges, output logic [63:0] se_tr);
    logic rv;
    @(negedge clk);
    pat_data = pat;
    exp_data = exp;
    if (sel) pat_valid2 = 1'b1; else pat_valid1 = 1'b1;
    @(negedge clk);
    pat_valid1 = 1'b0;
    pat_valid2 = 1'b0;
    edges = 0;
    se_tr = '0;
    se_tr[0] = sel ? se2 : se1;
    rv = sel ? b2.res_valid : b1.res_valid;
    while (!rv && edges < 40) begin
      @(negedge clk);
      edges++;
      se_tr[edges] = sel ? se2 : se1;
      rv = sel ? b2.res_valid : b1.res_valid;
    end
    total++;
    if (!rv) begin
      bad++;
      $display("FAIL run_timeout: res_valid=%b after %0d edges, required 1", rv, edges);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (b1.pat_ready !== 1'b1 || b1.res_valid !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: pat_ready=%b res_valid=%b busy=%b, required 1 0 0",
               b1.pat_ready, b1.res_valid, busy1);
    end
    total++;
    if (se1 !== 1'b0 || sd1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_scan: scan_en=%b scan_sd=%b, required 0 0", se1, sd1);
    end
    total++;
    if (b1.res_data !== 8'h00 || b1.res_mismatch !== 1'b0 || err1 !== 8'd0 || err2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_res: res_data=%h mismatch=%b err1=%0d err2=%0d, required 00 0 0 0",
               b1.res_data, b1.res_mismatch, err1, err2);
    end
    reset = 1'b0;
  endtask

  task automatic test_match();
    int edges;
    logic [63:0] tr;
    res_ready = 1'b1;
    run(1'b0, 8'hA5, 8'h5A, edges, tr);
    total++;
    if (b1.res_data !== 8'h5A || b1.res_mismatch !== 1'b0) begin
      bad++;
      $display("FAIL match_res: res_data=%h mismatch=%b, required 5a 0", b1.res_data, b1.res_mismatch);
    end
    handshake();
    total++;
    if (err1 !== 8'd0 || b1.res_valid !== 1'b0 || b1.pat_ready !== 1'b1) begin
      bad++;
      $display("FAIL match_hs: err=%0d res_valid=%b pat_ready=%b, required 0 0 1",
               err1, b1.res_valid, b1.pat_ready);
    end
  endtask

  task automatic test_mismatch();
    int edges;
    logic [63:0] tr;
    run(1'b0, 8'hA5, 8'h00, edges, tr);
    total++;
    if (b1.res_data !== 8'h5A || b1.res_mismatch !== 1'b1) begin
      bad++;
      $display("FAIL mismatch_res: res_data=%h mismatch=%b, required 5a 1", b1.res_data, b1.res_mismatch);
    end
    total++;
    if (err1 !== 8'd0) begin
      bad++;
      $display("FAIL mismatch_pre_hs: err=%0d, required 0", err1);
    end
    handshake();
    total++;
    if (err1 !== 8'd1) begin
      bad++;
      $display("FAIL mismatch_hs: err=%0d, required 1", err1);
    end
  endtask

  task automatic test_latency();
    int edges;
    logic [63:0] tr;
    run(1'b0, 8'h3C, 8'hC3, edges, tr);
    total++;
    if (edges !== 17) begin
      bad++;
      $display("FAIL latency: edges=%0d, required 17", edges);
    end
    total++;
    if (tr[17:0] !== 18'h1FEFF) begin
      bad++;
      $display("FAIL scan_en_profile: trace=%h, required 1feff", tr[17:0]);
    end
    total++;
    if (b1.res_data !== 8'hC3 || b1.res_mismatch !== 1'b0) begin
      bad++;
      $display("FAIL latency_res: res_data=%h mismatch=%b, required c3 0", b1.res_data, b1.res_mismatch);
    end
    handshake();
  endtask

  task automatic test_hold();
    int edges;
    logic [63:0] tr;
    run(1'b0, 8'h0F, 8'h00, edges, tr);
    pat_valid1 = 1'b1;
    pat_data   = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (b1.res_valid !== 1'b1 || b1.res_data !== 8'hF0 || b1.res_mismatch !== 1'b1) begin
        bad++;
        $display("FAIL hold_res[%0d]: res_valid=%b res_data=%h mismatch=%b, required 1 f0 1",
                 i, b1.res_valid, b1.res_data, b1.res_mismatch);
      end
      total++;
      if (b1.pat_ready !== 1'b0 || err1 !== 8'd1 || busy1 !== 1'b1) begin
        bad++;
        $display("FAIL hold_ctl[%0d]: pat_ready=%b err=%0d busy=%b, required 0 1 1",
                 i, b1.pat_ready, err1, busy1);
      end
    end
    pat_valid1 = 1'b0;
    handshake();
    total++;
    if (err1 !== 8'd2 || b1.res_valid !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL hold_hs: err=%0d res_valid=%b busy=%b, required 2 0 0", err1, b1.res_valid, busy1);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    logic [63:0] tr;
    @(negedge clk);
    pat_data   = 8'h81;
    exp_data   = 8'h00;
    pat_valid1 = 1'b1;
    @(negedge clk);
    pat_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (se1 !== 1'b0 || b1.pat_ready !== 1'b1 || busy1 !== 1'b0 || err1 !== 8'd0 || b1.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: scan_en=%b pat_ready=%b busy=%b err=%0d res_valid=%b, required 0 1 0 0 0",
               se1, b1.pat_ready, busy1, err1, b1.res_valid);
    end
    reset = 1'b0;
    run(1'b0, 8'hFF, 8'h00, edges, tr);
    total++;
    if (b1.res_data !== 8'h00 || b1.res_mismatch !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: res_data=%h mismatch=%b, required 00 0", b1.res_data, b1.res_mismatch);
    end
    handshake();
    total++;
    if (err1 !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid_err: err=%0d, required 0", err1);
    end
  endtask

  task automatic test_saturate();
    int edges;
    logic [63:0] tr;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 8'hA5, 8'h00, edges, tr);
      total++;
      if (b2.res_data !== 8'h5A || b2.res_mismatch !== 1'b1) begin
        bad++;
        $display("FAIL sat_res[%0d]: res_data=%h mismatch=%b, required 5a 1", i, b2.res_data, b2.res_mismatch);
      end
      handshake();
      total++;
      if (err2 !== exp_cnt[i]) begin
        bad++;
        $display("FAIL sat_count[%0d]: err=%0d, required %0d", i, err2, exp_cnt[i]);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    pat_valid1 = 1'b0;
    pat_valid2 = 1'b0;
    res_ready  = 1'b0;
    pat_data   = 8'h00;
    exp_data   = 8'h00;
    test_reset();
    test_match();
    test_mismatch();
    test_latency();
    test_hold();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
